muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Multicycle-path controller wrapped around the combinational divider and the combinational multiplier.
- Latches operands and holds them stable for a parameterised settle time.
- Captures the 64-bit result into the HI/LO registers and reports completion with a busy/done handshake.
- Sits between the datapath bus/control unit and the HI/LO register pair.

Parameters:
WIDTH, 32, operand and HI/LO width
DIV_SETTLE, 4, cycles the divider result needs after operands change (legal range 1..15)
MUL_SETTLE, 2, cycles the multiplier result needs after operands change (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request a new operation; sampled only in IDLE
op_div  in  1  1 = divide, 0 = multiply; sampled with start
op_a  in  WIDTH  dividend / multiplicand
op_b  in  WIDTH  divisor / multiplier
opnd_a  out  WIDTH  registered operand driven to divider and multiplier
opnd_b  out  WIDTH  registered operand driven to divider and multiplier
div_result  in  2*WIDTH  divider output {remainder, quotient}
mul_result  in  2*WIDTH  multiplier output {high, low}
hi_we  in  1  direct write of bus_in to HI
lo_we  in  1  direct write of bus_in to LO
bus_in  in  WIDTH  direct-write data
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
div_zero  out  1  last accepted divide had op_b == 0; sticky

Behaviour:
- Reset (async, active-high): state=IDLE; opnd_a, opnd_b, hi, lo, counter = 0; busy=0, done=0, div_zero=0.
- States: IDLE, WAIT, DONE.
- IDLE, start=1 at edge N:
  - opnd_a<=op_a, opnd_b<=op_b, op latched.
  - div_zero<=0.
  - counter <= (op_div ? DIV_SETTLE : MUL_SETTLE) - 1.
  - Go to WAIT.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: capture at that edge, then go to DONE.
  - Capture is therefore at edge N+SETTLE.
- Capture, divide: hi<=div_result[63:32] (remainder), lo<=div_result[31:0] (quotient), div_zero<=(opnd_b==0).
- Capture, multiply: hi<=mul_result[63:32], lo<=mul_result[31:0].
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- busy = (state==WAIT).
- done is a registered state decode, never combinational from inputs.
- start while in WAIT or DONE: ignored, not queued; operands and latched op unchanged.
- opnd_a/opnd_b hold their value after completion until the next accepted start.
- Direct writes:
  - hi_we/lo_we write bus_in in any state.
  - On the same edge as a capture, capture wins and the direct write is dropped.
  - hi_we and lo_we may both be high and write both registers.
- Divide-by-zero: hi/lo take whatever the divider outputs (remainder=dividend, quotient=0); no trap.
- reset mid-WAIT: immediate return to IDLE; hi/lo cleared; no done pulse.
- Counter width 4 bits. The multiplier result is unused on divides and vice versa.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2)
  - op encoding (OP_MUL=1'b0, OP_DIV=1'b1)
  - default settle constants
- One natural sub-module: muldiv_settle_timer.
  - Load value, decrement, zero flag.
  - Async active-high reset.
- The FSM, operand latches and HI/LO registers stay in the top.

Test Plan:
- 100 / 7, DIV_SETTLE=4:
  - busy high 4 cycles.
  - lo=14, hi=2, done pulses once, div_zero=0.
- -7 / 2:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- 5 / 0:
  - lo=0, hi=5, div_zero=1.
  - div_zero stays 1 until next start, then clears.
- 0x00010000 * 0x00010000, MUL_SETTLE=2:
  - hi=1, lo=0 at edge N+2, done next cycle.
- start pulsed during WAIT with different operands:
  - ignored; first result captured.
  - opnd_a unchanged.
- hi_we with bus_in=0xDEADBEEF asserted on the capture edge:
  - hi = captured value.
  - Same write in IDLE: hi=0xDEADBEEF.
- reset asserted mid-WAIT:
  - outputs 0 asynchronously, no done pulse.
  - Next start works normally.

Source files
------------

// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared encodings and defaults for the HI/LO multicycle controller.
package muldiv_hilo_ctrl_pkg;

    localparam int CNT_W            = 4;
    localparam int DEF_DIV_SETTLE   = 4;
    localparam int DEF_MUL_SETTLE   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

endpackage

// File: rtl/muldiv_settle_timer.sv
// Down-counter that measures the settle time of the combinational divider/multiplier.
module muldiv_settle_timer
    import muldiv_hilo_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Holds operands stable for the divider/multiplier settle time, then captures the
// 64-bit result into HI/LO and signals completion with a busy/done handshake.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIV_SETTLE = DEF_DIV_SETTLE,
    parameter int MUL_SETTLE = DEF_MUL_SETTLE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               op_div,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [WIDTH-1:0]   opnd_a,
    output logic [WIDTH-1:0]   opnd_b,
    input  logic [2*WIDTH-1:0] div_result,
    input  logic [2*WIDTH-1:0] mul_result,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [WIDTH-1:0]   bus_in,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_SETTLE - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_SETTLE - 1);

    state_t             state;
    state_t             state_nxt;
    op_t                op_q;
    logic               accept;
    logic               capture;
    logic               timer_zero;
    logic [CNT_W-1:0]   load_val;
    logic [2*WIDTH-1:0] result;

    assign accept   = (state == ST_IDLE) && start;
    assign capture  = (state == ST_WAIT) && timer_zero;
    assign load_val = op_div ? DIV_LOAD : MUL_LOAD;
    assign result   = (op_q == OP_DIV) ? div_result : mul_result;

    muldiv_settle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (load_val),
        .dec      (state == ST_WAIT),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)      state_nxt = ST_WAIT;
            ST_WAIT: if (timer_zero) state_nxt = ST_DONE;
            ST_DONE:                 state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_WAIT);
        done = (state == ST_DONE);
    end

    // Operands stay frozen from acceptance until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opnd_a <= '0;
            opnd_b <= '0;
            op_q   <= OP_MUL;
        end else if (accept) begin
            opnd_a <= op_a;
            opnd_b <= op_b;
            op_q   <= op_div ? OP_DIV : OP_MUL;
        end
    end

    // A capture on the same edge as a direct write takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (capture) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
        end else begin
            if (hi_we) hi <= bus_in;
            if (lo_we) lo <= bus_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_zero <= 1'b0;
        end else if (accept) begin
            div_zero <= 1'b0;
        end else if (capture && (op_q == OP_DIV)) begin
            div_zero <= (opnd_b == '0);
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl with behavioural divider/multiplier models.
module tb_muldiv_hilo_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           op_div;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   opnd_a;
    logic [W-1:0]   opnd_b;
    logic [2*W-1:0] div_result;
    logic [2*W-1:0] mul_result;
    logic           hi_we;
    logic           lo_we;
    logic [W-1:0]   bus_in;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           busy;
    logic           done;
    logic           div_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_hilo_ctrl #(.WIDTH(W), .DIV_SETTLE(4), .MUL_SETTLE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_div     (op_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .div_result (div_result),
        .mul_result (mul_result),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .bus_in     (bus_in),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    // Signed truncating divider; divide-by-zero yields remainder=dividend, quotient=0.
    always_comb begin
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        sa = $signed(opnd_a);
        sb = $signed(opnd_b);
        q  = '0;
        r  = sa;
        if (sb != 0) begin
            q = sa / sb;
            r = sa % sb;
        end
        div_result = {r, q};
        mul_result = {32'h0, opnd_a} * {32'h0, opnd_b};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issues one start and counts busy/done cycles over a fixed window.
    task automatic run_op(input logic div, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int busy_cyc, output int done_cyc);
        @(negedge clk);
        start = 1'b1; op_div = div; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        done_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cyc++;
            if (done) done_cyc++;
            @(negedge clk);
        end
    endtask

    int bc, dc;

    initial begin
        reset = 1'b1; start = 1'b0; op_div = 1'b0; op_a = '0; op_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; bus_in = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_opnd_a", opnd_a, 0);
        chk("reset_divz", div_zero, 0);
        reset = 1'b0;

        // 100 / 7
        run_op(1'b1, 32'd100, 32'd7, bc, dc);
        chk("div100_busy_cycles", bc, 4);
        chk("div100_done_pulses", dc, 1);
        chk("div100_lo", lo, 14);
        chk("div100_hi", hi, 2);
        chk("div100_divz", div_zero, 0);

        // -7 / 2
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, bc, dc);
        chk("divneg_lo", lo, 32'hFFFF_FFFD);
        chk("divneg_hi", hi, 32'hFFFF_FFFF);

        // 5 / 0
        run_op(1'b1, 32'd5, 32'd0, bc, dc);
        chk("div0_lo", lo, 0);
        chk("div0_hi", hi, 5);
        chk("div0_divz", div_zero, 1);
        repeat (3) @(negedge clk);
        chk("div0_divz_sticky", div_zero, 1);

        // 0x10000 * 0x10000 with edge-accurate capture timing
        start = 1'b1; op_div = 1'b0; op_a = 32'h0001_0000; op_b = 32'h0001_0000;
        @(negedge clk);          // edge N accepted
        start = 1'b0;
        chk("mul_divz_cleared", div_zero, 0);
        chk("mul_busy_n", busy, 1);
        @(negedge clk);          // after N+1
        chk("mul_hi_n1", hi, 5);
        chk("mul_done_n1", done, 0);
        @(negedge clk);          // after N+2: captured
        chk("mul_hi_n2", hi, 1);
        chk("mul_lo_n2", lo, 0);
        chk("mul_busy_n2", busy, 0);
        chk("mul_done_n2", done, 1);
        @(negedge clk);
        chk("mul_done_n3", done, 0);

        // start during WAIT is ignored
        start = 1'b1; op_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op_div = 1'b0; op_a = 32'd50; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("ign_opnd_a", opnd_a, 100);
        chk("ign_opnd_b", opnd_b, 7);
        repeat (5) @(negedge clk);
        chk("ign_lo", lo, 14);
        chk("ign_hi", hi, 2);

        // direct write colliding with capture: capture wins
        start = 1'b1; op_div = 1'b1; op_a = 32'd23; op_b = 32'd5;
        @(negedge clk);          // edge N
        start = 1'b0;
        repeat (3) @(negedge clk); // after N+3
        hi_we = 1'b1; bus_in = 32'hDEAD_BEEF;
        @(negedge clk);          // edge N+4 = capture
        hi_we = 1'b0;
        chk("coll_hi", hi, 3);
        chk("coll_lo", lo, 4);
        @(negedge clk);
        hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        chk("idle_hi_we", hi, 32'hDEAD_BEEF);
        chk("idle_lo_kept", lo, 4);
        hi_we = 1'b1; lo_we = 1'b1; bus_in = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both_we_hi", hi, 32'h1234_5678);
        chk("both_we_lo", lo, 32'h1234_5678);

        // reset mid-WAIT
        start = 1'b1; op_div = 1'b1; op_a = 32'd9; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_hi", hi, 0);
        chk("rst_async_lo", lo, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_opnd_a", opnd_a, 0);
        @(negedge clk);
        reset = 1'b0;
        dc = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dc++;
            @(negedge clk);
        end
        chk("rst_no_done", dc, 0);
        run_op(1'b1, 32'd9, 32'd2, bc, dc);
        chk("post_rst_busy", bc, 4);
        chk("post_rst_done", dc, 1);
        chk("post_rst_lo", lo, 4);
        chk("post_rst_hi", hi, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
